pim_dispatcher: RTL and testbench

- PIM-controller side of the memory↔PIM link.
- Accepts operand-vector jobs (A row, B column, destination address) from the memory block over a valid/ready handshake.
- Dispatches each job to an idle PIM lane, where a sequential MAC computes the dot product.
- Returns each result with its destination address to memory writeback through an in-order result FIFO.

---
 rtl/pim_dispatcher_if.sv | 28 ++
 rtl/pim_dispatcher.sv | 196 +++++++++++++++++++
 tb/tb_pim_dispatcher.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pim_dispatcher_if.sv
// pim_dispatcher_if: job-in and result-out handshake bundle between the memory
// block (master) and the PIM dispatcher (slave).
interface pim_dispatcher_if #(
  parameter int WIDTH     = 8,
  parameter int SIZE      = 4,
  parameter int LEN       = 10,
  parameter int ACC_WIDTH = 2 * WIDTH + $clog2(SIZE)
);
  logic                  in_valid;
  logic                  in_ready;
  logic [SIZE*WIDTH-1:0] in_a;
  logic [SIZE*WIDTH-1:0] in_b;
  logic [LEN-1:0]        in_dest;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  out_data;
  logic [LEN-1:0]        out_dest;

  modport master (
    output in_valid, in_a, in_b, in_dest, out_ready,
    input  in_ready, out_valid, out_data, out_dest
  );

  modport slave (
    input  in_valid, in_a, in_b, in_dest, out_ready,
    output in_ready, out_valid, out_data, out_dest
  );
endinterface

// File: rtl/pim_dispatcher.sv
// pim_dispatcher: accepts operand-vector jobs, runs each on the lowest idle
// enabled PIM lane as a sequential MAC, and returns the dot products with
// their destination addresses in acceptance order through a result FIFO.
// Build option: define PIM_SIGNED_EN for two's-complement operands and
// results; leave it undefined for unsigned arithmetic.
module pim_dispatcher #(
  parameter int WIDTH      = 8,
  parameter int SIZE       = 4,
  parameter int LEN        = 10,
  parameter int NUM_PIMS   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ACC_WIDTH  = 2 * WIDTH + $clog2(SIZE)
) (
  input  logic                          clk,
  input  logic                          rst,
  pim_dispatcher_if.slave               bus,
  input  logic [$clog2(NUM_PIMS+1)-1:0] no_of_pims,
  output logic                          busy
);
  localparam int CNT_W  = $clog2(SIZE);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LANE_W = $clog2(NUM_PIMS + 1);

  typedef enum logic {IDLE, RUN} lane_state_e;

  lane_state_e          state_q [NUM_PIMS];
  lane_state_e          state_d [NUM_PIMS];
  logic [WIDTH-1:0]     a_q     [NUM_PIMS][SIZE];
  logic [WIDTH-1:0]     b_q     [NUM_PIMS][SIZE];
  logic [LEN-1:0]       dest_q  [NUM_PIMS];
  logic [CNT_W-1:0]     cnt_q   [NUM_PIMS];
  logic [ACC_WIDTH-1:0] acc_q   [NUM_PIMS];
  logic [ACC_WIDTH-1:0] sum     [NUM_PIMS];

  logic [LANE_W-1:0]    eff;
  logic [LANE_W-1:0]    running;
  logic [LANE_W-1:0]    sel_idx;
  logic                 sel_found;
  logic                 credit_ok;
  logic                 accept;

  logic                 push;
  logic [ACC_WIDTH-1:0] push_data;
  logic [LEN-1:0]       push_dest;
  logic                 pop;
  logic [ACC_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [LEN-1:0]       fifo_dest [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     head_ptr;
  logic [PTR_W:0]       count_q;

  // One element product, widened to the accumulator width.
  function automatic logic [ACC_WIDTH-1:0] elem_product(input logic [WIDTH-1:0] x,
                                                        input logic [WIDTH-1:0] y);
`ifdef PIM_SIGNED_EN
    logic signed [WIDTH-1:0] xs;
    logic signed [WIDTH-1:0] ys;
    xs = x;
    ys = y;
    return ACC_WIDTH'(xs) * ACC_WIDTH'(ys);
`else
    return ACC_WIDTH'(x) * ACC_WIDTH'(y);
`endif
  endfunction

  // Effective lane count, lowest idle enabled lane and the FIFO credit check.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment, so no latch is inferred.
    eff       = no_of_pims;
    running   = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    if (no_of_pims == '0) begin
      eff = LANE_W'(1);
    end else if (no_of_pims > LANE_W'(NUM_PIMS)) begin
      eff = LANE_W'(NUM_PIMS);
    end
    // Walk downward so the lowest-index idle enabled lane wins.
    for (int i = NUM_PIMS - 1; i >= 0; i--) begin
      if (state_q[i] == RUN) running = running + LANE_W'(1);
      if (state_q[i] == IDLE && LANE_W'(i) < eff) begin
        sel_idx   = LANE_W'(i);
        sel_found = 1'b1;
      end
    end
    // Every running lane holds a reserved FIFO slot, so the FIFO cannot overflow.
    credit_ok    = (int'(count_q) + int'(running)) < FIFO_DEPTH;
    bus.in_ready = rst && sel_found && credit_ok;
    accept       = bus.in_valid && bus.in_ready;
  end

  // Lane next-state, MAC sums and the single FIFO push per edge.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    push_dest = '0;
    for (int i = 0; i < NUM_PIMS; i++) begin
      sum[i]     = acc_q[i] + elem_product(a_q[i][cnt_q[i]], b_q[i][cnt_q[i]]);
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE: if (accept && sel_idx == LANE_W'(i)) state_d[i] = RUN;
        RUN: begin
          // Fixed latency means at most one lane finishes on any edge.
          if (cnt_q[i] == CNT_W'(SIZE - 1)) begin
            state_d[i] = IDLE;
            push       = 1'b1;
            push_data  = sum[i];
            push_dest  = dest_q[i];
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // Lane state register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      for (int i = 0; i < NUM_PIMS; i++) state_q[i] <= IDLE;
    end else begin
      for (int i = 0; i < NUM_PIMS; i++) state_q[i] <= state_d[i];
    end
  end

  // Lane counter, accumulator and destination capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PIMS; i++) begin
        cnt_q[i]  <= '0;
        acc_q[i]  <= '0;
        dest_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PIMS; i++) begin
        if (state_q[i] == IDLE && state_d[i] == RUN) begin
          cnt_q[i]  <= '0;
          acc_q[i]  <= '0;
          dest_q[i] <= bus.in_dest;
        end else if (state_q[i] == RUN) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          acc_q[i] <= sum[i];
        end
      end
    end
  end

  // Operand capture into the selected lane.
  // NOTE: operand storage has no reset; a lane always reloads it on accept before reading it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PIMS; i++) begin
      if (state_q[i] == IDLE && state_d[i] == RUN) begin
        for (int j = 0; j < SIZE; j++) begin
          a_q[i][j] <= bus.in_a[j*WIDTH +: WIDTH];
          b_q[i][j] <= bus.in_b[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Result FIFO storage, pointers and occupancy.
  // Storage is cleared here because the empty-FIFO output shows the slot behind
  // the read pointer, which must read as zero straight after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_dest[i] <= '0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= push_data;
        fifo_dest[wr_ptr] <= push_dest;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // When empty, the head points at the last popped entry so the outputs hold.
  assign pop           = (count_q != '0) && bus.out_ready;
  assign head_ptr      = (count_q == '0) ? rd_ptr - PTR_W'(1) : rd_ptr;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = fifo_data[head_ptr];
  assign bus.out_dest  = fifo_dest[head_ptr];
  assign busy          = (running != '0) || (count_q != '0);
endmodule

// File: tb/tb_pim_dispatcher.sv
// tb_pim_dispatcher: table-driven single jobs, hand-written multi-job corner
// sequences and a randomized phase, all checked every cycle against a
// transaction-level model (lane occupancy times and an in-order result queue).
module tb_pim_dispatcher;
  localparam int WIDTH      = 8;
  localparam int SIZE       = 4;
  localparam int LEN        = 10;
  localparam int NUM_PIMS   = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int ACC_WIDTH  = 2 * WIDTH + $clog2(SIZE);
  localparam int NP_W       = $clog2(NUM_PIMS + 1);
  localparam int VW         = SIZE * WIDTH;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP_W-1:0] no_of_pims;
  logic            busy;

  always #5 clk = ~clk;

  pim_dispatcher_if #(.WIDTH(WIDTH), .SIZE(SIZE), .LEN(LEN), .ACC_WIDTH(ACC_WIDTH)) bus ();

  pim_dispatcher #(
    .WIDTH(WIDTH), .SIZE(SIZE), .LEN(LEN), .NUM_PIMS(NUM_PIMS),
    .FIFO_DEPTH(FIFO_DEPTH), .ACC_WIDTH(ACC_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .no_of_pims(no_of_pims), .busy(busy)
  );

  typedef struct { logic [VW-1:0] a; logic [VW-1:0] b; logic [LEN-1:0] dest; } job_t;
  typedef struct { logic [ACC_WIDTH-1:0] data; logic [LEN-1:0] dest; int ready_edge; } res_t;
  typedef struct {
    logic [VW-1:0] a; logic [VW-1:0] b; logic [LEN-1:0] dest;
    logic [ACC_WIDTH-1:0] exp_u; logic [ACC_WIDTH-1:0] exp_s;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_idx = 0;
  int lane_free [NUM_PIMS];
  res_t model_q [$];
  job_t pend [$];
  logic [ACC_WIDTH-1:0] last_data;
  logic [LEN-1:0]       last_dest;
  logic [ACC_WIDTH-1:0] got_data [$];
  logic [LEN-1:0]       got_dest [$];
  int acc_edges [$];
  int pop_edges [$];
  logic ordy;
  logic offer;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Dot product straight from the arithmetic rules.
  function automatic logic [ACC_WIDTH-1:0] ref_dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
    longint s = 0;
    for (int i = 0; i < SIZE; i++) begin
`ifdef PIM_SIGNED_EN
      s += longint'($signed(a[i*WIDTH +: WIDTH])) * longint'($signed(b[i*WIDTH +: WIDTH]));
`else
      s += longint'(a[i*WIDTH +: WIDTH]) * longint'(b[i*WIDTH +: WIDTH]);
`endif
    end
    return ACC_WIDTH'(s);
  endfunction

  // One clock cycle: drive, sample away from the edge, compare with the model, advance.
  task automatic cycle();
    int   eff;
    int   sel;
    bit   exp_ready;
    bit   exp_valid;
    bit   acc;
    bit   pop;
    res_t r;
    if (offer && pend.size() != 0) begin
      bus.in_valid = 1'b1;
      bus.in_a     = pend[0].a;
      bus.in_b     = pend[0].b;
      bus.in_dest  = pend[0].dest;
    end else begin
      bus.in_valid = 1'b0;
      bus.in_a     = VW'($urandom);
      bus.in_b     = VW'($urandom);
      bus.in_dest  = LEN'($urandom);
    end
    bus.out_ready = ordy;
    #1;
    eff = (no_of_pims == 0) ? 1 : ((int'(no_of_pims) > NUM_PIMS) ? NUM_PIMS : int'(no_of_pims));
    sel = -1;
    for (int i = eff - 1; i >= 0; i--) if (lane_free[i] <= edge_idx) sel = i;
    exp_ready = (sel >= 0) && (model_q.size() < FIFO_DEPTH);
    exp_valid = (model_q.size() != 0) && (model_q[0].ready_edge <= edge_idx);
    check("in_ready", bus.in_ready, exp_ready);
    check("out_valid", bus.out_valid, exp_valid);
    check("busy", busy, model_q.size() != 0);
    if (exp_valid) begin
      check("out_data", bus.out_data, model_q[0].data);
      check("out_dest", bus.out_dest, model_q[0].dest);
    end else begin
      check("held_data", bus.out_data, last_data);
      check("held_dest", bus.out_dest, last_dest);
    end
    acc = bus.in_valid && exp_ready;
    pop = exp_valid && ordy;
    if (pop) begin
      r = model_q.pop_front();
      last_data = r.data;
      last_dest = r.dest;
      got_data.push_back(bus.out_data);
      got_dest.push_back(bus.out_dest);
      pop_edges.push_back(edge_idx);
    end
    if (acc) begin
      lane_free[sel] = edge_idx + SIZE + 1;
      r.data       = ref_dot(pend[0].a, pend[0].b);
      r.dest       = pend[0].dest;
      r.ready_edge = edge_idx + SIZE + 1;
      model_q.push_back(r);
      acc_edges.push_back(edge_idx);
      void'(pend.pop_front());
    end
    edge_idx++;
    @(negedge clk);
  endtask

  task automatic clear_log();
    got_data.delete();
    got_dest.delete();
    acc_edges.delete();
    pop_edges.delete();
  endtask

  task automatic run_until(input int n_pops, input int budget, input string tag);
    int k = 0;
    while (got_data.size() < n_pops && k < budget) begin
      cycle();
      k++;
    end
    check({tag, "_result_count"}, got_data.size(), n_pops);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop without a clock edge.
  task automatic apply_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_out_dest"}, bus.out_dest, 0);
    model_q.delete();
    pend.delete();
    foreach (lane_free[i]) lane_free[i] = 0;
    last_data = '0;
    last_dest = '0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_in_ready_held"}, bus.in_ready, 0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [5];
    logic [ACC_WIDTH-1:0] exp;
    int k;

    vecs[0] = '{a: 32'h04030201, b: 32'h08070605, dest: 10'h010, exp_u: 70,     exp_s: 70};
    vecs[1] = '{a: 32'h04FD02FF, b: 32'h01010101, dest: 10'h011, exp_u: 514,    exp_s: 2};
    vecs[2] = '{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, dest: 10'h3FF, exp_u: 260100, exp_s: 4};
    vecs[3] = '{a: 32'h00007F80, b: 32'h00008080, dest: 10'h155, exp_u: 32640,  exp_s: 128};
    vecs[4] = '{a: 32'h00000000, b: 32'hA5C3FF11, dest: 10'h2AA, exp_u: 0,      exp_s: 0};

    rst           = 1'b1;
    no_of_pims    = NP_W'(4);
    ordy          = 1'b1;
    offer         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_dest   = '0;
    bus.out_ready = 1'b1;
    last_data     = '0;
    last_dest     = '0;
    foreach (lane_free[i]) lane_free[i] = 0;
    @(negedge clk);
    apply_reset("reset");

    // Single jobs from the table: result, destination, latency, idle afterwards.
    offer = 1'b1;
    for (int v = 0; v < 5; v++) begin
      clear_log();
      pend.push_back('{a: vecs[v].a, b: vecs[v].b, dest: vecs[v].dest});
`ifdef PIM_SIGNED_EN
      exp = vecs[v].exp_s;
`else
      exp = vecs[v].exp_u;
`endif
      run_until(1, 30, "single");
      if (got_data.size() == 1 && acc_edges.size() == 1) begin
        check("single_data", got_data[0], exp);
        check("single_dest", got_dest[0], vecs[v].dest);
        check("single_latency", pop_edges[0] - acc_edges[0], SIZE + 1);
      end
      cycle();
      check("single_idle_busy", busy, 0);
    end

    // Four back-to-back jobs on four lanes.
    clear_log();
    for (int j = 1; j <= 4; j++)
      pend.push_back('{a: {SIZE{8'(j)}}, b: {SIZE{8'h01}}, dest: LEN'(10'h020 + j - 1)});
    run_until(4, 40, "b2b");
    if (got_data.size() == 4 && acc_edges.size() == 4) begin
      for (int j = 0; j < 4; j++) begin
        check("b2b_accept_edge", acc_edges[j] - acc_edges[0], j);
        check("b2b_data", got_data[j], 4 * (j + 1));
        check("b2b_dest", got_dest[j], 10'h020 + j);
      end
    end

    // One enabled lane: the second job waits for the first to finish.
    clear_log();
    no_of_pims = NP_W'(1);
    pend.push_back('{a: 32'h01010101, b: 32'h02020202, dest: 10'h040});
    pend.push_back('{a: 32'h03030303, b: 32'h01010101, dest: 10'h041});
    run_until(2, 40, "one_lane");
    if (got_data.size() == 2 && acc_edges.size() == 2) begin
      check("one_lane_gap", acc_edges[1] - acc_edges[0], SIZE + 1);
      check("one_lane_data0", got_data[0], 8);
      check("one_lane_data1", got_data[1], 12);
      check("one_lane_dest1", got_dest[1], 10'h041);
    end

    // Credit limit: writeback stalled, five jobs offered, only four fit.
    clear_log();
    no_of_pims = NP_W'(4);
    ordy = 1'b0;
    for (int j = 1; j <= 5; j++)
      pend.push_back('{a: {SIZE{8'(j)}}, b: {SIZE{8'h01}}, dest: LEN'(10'h030 + j - 1)});
    for (int c = 0; c < 15; c++) cycle();
    check("credit_accepts", acc_edges.size(), 4);
    check("credit_pending", pend.size(), 1);
    ordy = 1'b1;
    run_until(5, 60, "credit");
    check("credit_all_accepted", acc_edges.size(), 5);
    if (got_data.size() == 5) begin
      for (int j = 0; j < 5; j++) begin
        check("credit_data", got_data[j], 4 * (j + 1));
        check("credit_dest", got_dest[j], 10'h030 + j);
      end
    end

    // Reset with one result queued and one lane still running.
    clear_log();
    ordy = 1'b0;
    pend.push_back('{a: 32'h05050505, b: 32'h01010101, dest: 10'h050});
    pend.push_back('{a: 32'h06060606, b: 32'h01010101, dest: 10'h051});
    for (int c = 0; c < SIZE + 1; c++) cycle();
    check("pre_reset_valid", bus.out_valid, 1);
    check("pre_reset_busy", busy, 1);
    apply_reset("midrst");
    clear_log();
    ordy = 1'b1;
    pend.push_back('{a: 32'h02020202, b: 32'h03030303, dest: 10'h0AB});
    run_until(1, 30, "post_reset");
    if (got_data.size() == 1) begin
      check("post_reset_data", got_data[0], 24);
      check("post_reset_dest", got_dest[0], 10'h0AB);
    end
    for (int c = 0; c < 10; c++) cycle();
    check("post_reset_no_stale", got_data.size(), 1);

    // Randomized traffic, lane count and backpressure.
    for (int c = 0; c < 600; c++) begin
      no_of_pims = NP_W'($urandom_range(0, 7));
      ordy       = ($urandom_range(0, 3) != 0);
      offer      = ($urandom_range(0, 2) != 0);
      if (pend.size() < 3)
        pend.push_back('{a: VW'($urandom), b: VW'($urandom), dest: LEN'($urandom)});
      cycle();
    end
    offer = 1'b1;
    ordy  = 1'b1;
    no_of_pims = NP_W'(4);
    k = 0;
    while ((pend.size() != 0 || model_q.size() != 0) && k < 300) begin
      cycle();
      k++;
    end
    check("random_drained", pend.size() + model_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
